// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// Arbiter state, owner tag and the fixed fetch size code.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of fetch losses to the data port.
// at_max forces the next contested grant to fetch.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == W'(MAX));

  // next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for one fixed-latency memory port.
// Data wins ties unless fetch has lost too many times.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;

  logic idle, resp, at_max;
  logic if_win, d_win;
  logic if_g, d_g;

  assign idle   = (state_q == IDLE);
  assign resp   = (state_q == WAIT)
               && (cnt_q == CW'(1));
  assign if_win = idle && if_req
               && (!d_req || at_max);
  assign d_win  = idle && d_req && !if_win;

  // grants are masked while reset is held
  assign if_g = if_win && reset;
  assign d_g  = d_win && reset;

  starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (if_win),
    .inc   (d_win && if_req),
    .at_max(at_max)
  );

  // issue on grant, count down latency, release on response
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    if (if_win || d_win) begin
      state_d = WAIT;
      cnt_d   = CW'(MEM_LAT);
      we_d    = d_win && d_we;
      if (if_win)
        owner_d = OWN_IF;
      else
        owner_d = OWN_D;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 1'b1;
      if (resp) begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
      end
    end
  end

  // state, owner and latency registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  // memory request fields come from the winner only
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    unique case (1'b1)
      if_g: begin
        mem_addr = if_addr;
        mem_size = SIZE_WORD;
      end
      d_g: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_size  = d_size;
      end
      default: ;
    endcase
  end

  assign if_gnt    = if_g;
  assign d_gnt     = d_g;
  assign mem_en    = if_g || d_g;
  assign busy      = (state_q == WAIT);
  assign if_rvalid = resp
                  && (owner_q == OWN_IF);
  assign d_rvalid  = resp
                  && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !we_q)
                   ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios
// plus random traffic against a timestamp model.
module tb_unified_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_size;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  mem_size;
  logic [137:0] outs;

  int cyc = 0;
  int errs = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;
  rsp_t rq[$];

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  assign outs = {if_gnt, if_rvalid, if_rdata,
                 d_gnt, d_rvalid, d_rdata,
                 mem_en, mem_we, mem_addr,
                 mem_wdata, mem_size, busy};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory contents: a few fixed words, the rest hashed
  function automatic logic [31:0] mem_val(
    input logic [31:0] a);
    if (a == 32'h40)  return 32'h00500093;
    if (a == 32'h200) return 32'h11;
    if (a == 32'h204) return 32'h22;
    return (a * 32'h9E3779B1) ^ 32'h5A5AF00D;
  endfunction

  // fixed-latency memory: noise except on the due cycle
  always @(negedge clk)
    if (mem_en)
      rq.push_back('{due: cyc + MEM_LAT,
                     addr: mem_addr});

  always @(posedge clk) begin
    #1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rdata = mem_val(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      mem_rdata = $urandom;
    end
  end

  // requesters must hold fields until granted
  a_if_stable: assert property (
    @(posedge clk) disable iff (!reset)
    (if_req && !if_gnt) |=>
      (!if_req || $stable(if_addr)));

  a_d_stable: assert property (
    @(posedge clk) disable iff (!reset)
    (d_req && !d_gnt) |=>
      (!d_req ||
       $stable({d_we, d_addr, d_wdata, d_size})));

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_in();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_size  = 3'b000;
  endtask

  task automatic idle_cycles(input int n);
    clr_in();
    repeat (n) nxt();
    clr_in();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hFFFF;
    d_size  = 3'b111;
    repeat (3) nxt();
    smp();
    checks++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL reset_outputs got %h want 0",
               outs);
    end
    nxt();
    clr_in();
    reset = 1'b1;
    smp();
    checks++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL idle_no_req got %h want 0",
               outs);
    end
  endtask

  task automatic test_lone_fetch();
    nxt();
    if_req  = 1'b1;
    if_addr = 32'h40;
    smp();
    checks++;
    if ({if_gnt, mem_en, mem_we, d_gnt, busy}
        !== 5'b11000) begin
      errs++;
      $display("FAIL fetch_grant got %b want 11000",
               {if_gnt, mem_en, mem_we, d_gnt, busy});
    end
    checks++;
    if (mem_addr !== 32'h40 || mem_size !== 3'b010
        || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL fetch_fields got %h/%b/%h want 40/010/0",
               mem_addr, mem_size, mem_wdata);
    end
    nxt();
    if_req  = 1'b0;
    if_addr = $urandom;
    smp();
    checks++;
    if ({if_rvalid, busy, mem_en} !== 3'b010
        || if_rdata !== 32'h0) begin
      errs++;
      $display("FAIL fetch_wait got %b rdata %h want 010 rdata 0",
               {if_rvalid, busy, mem_en}, if_rdata);
    end
    nxt();
    smp();
    checks++;
    if ({if_rvalid, busy, d_rvalid} !== 3'b110
        || if_rdata !== 32'h00500093) begin
      errs++;
      $display("FAIL fetch_resp got %b rdata %h want 110 rdata 00500093",
               {if_rvalid, busy, d_rvalid}, if_rdata);
    end
    nxt();
    smp();
    checks++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL fetch_idle got %h want 0", outs);
    end
    idle_cycles(1);
  endtask

  task automatic test_store();
    nxt();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hAB;
    d_size  = 3'b000;
    smp();
    checks++;
    if ({d_gnt, mem_en, mem_we, if_gnt} !== 4'b1110
        || mem_addr !== 32'h100 || mem_wdata !== 32'hAB
        || mem_size !== 3'b000) begin
      errs++;
      $display("FAIL store_grant got %b %h %h %b want 1110 100 ab 000",
               {d_gnt, mem_en, mem_we, if_gnt},
               mem_addr, mem_wdata, mem_size);
    end
    nxt();
    clr_in();
    smp();
    nxt();
    smp();
    checks++;
    if ({d_rvalid, if_rvalid, busy} !== 3'b101
        || d_rdata !== 32'h0) begin
      errs++;
      $display("FAIL store_resp got %b rdata %h want 101 rdata 0",
               {d_rvalid, if_rvalid, busy}, d_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_simultaneous();
    bit ip = 1'b1;
    bit dp = 1'b1;
    logic [31:0] ei, ed;
    for (int k = 0; k < 6; k++) begin
      nxt();
      if_req  = ip;
      if_addr = 32'h80;
      d_req   = dp;
      d_we    = 1'b0;
      d_addr  = 32'h300;
      d_wdata = 32'h0;
      d_size  = 3'b010;
      smp();
      checks++;
      if ({d_gnt, d_rvalid, if_gnt, if_rvalid} !==
          {k == 0, k == 2, k == 3, k == 5}) begin
        errs++;
        $display("FAIL simul_strobes k=%0d got %b want %b", k,
                 {d_gnt, d_rvalid, if_gnt, if_rvalid},
                 {k == 0, k == 2, k == 3, k == 5});
      end
      ed = (k == 2) ? mem_val(32'h300) : 32'h0;
      ei = (k == 5) ? mem_val(32'h80) : 32'h0;
      checks++;
      if (d_rdata !== ed || if_rdata !== ei) begin
        errs++;
        $display("FAIL simul_rdata k=%0d got %h/%h want %h/%h",
                 k, d_rdata, if_rdata, ed, ei);
      end
      if (d_gnt) dp = 1'b0;
      if (if_gnt) ip = 1'b0;
    end
    idle_cycles(1);
  endtask

  task automatic test_starvation();
    logic [9:0]  pat = 10'b10_0001_0000;
    logic [31:0] ia = 32'h44;
    logic [31:0] da = 32'h500;
    int g = 0;
    for (int t = 0; t < 60 && g < 10; t++) begin
      nxt();
      if_req  = 1'b1;
      if_addr = ia;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = da;
      d_wdata = 32'h0;
      d_size  = 3'b010;
      smp();
      if (if_gnt || d_gnt) begin
        checks++;
        if (if_gnt !== pat[g] || d_gnt !== ~pat[g]) begin
          errs++;
          $display("FAIL starve_grant n=%0d got if=%b d=%b want if=%b",
                   g, if_gnt, d_gnt, pat[g]);
        end
        if (if_gnt) ia = ia + 32'd4;
        if (d_gnt) da = da + 32'd4;
        g++;
      end
    end
    checks++;
    if (g != 10) begin
      errs++;
      $display("FAIL starve_timeout got %0d grants want 10", g);
    end
    idle_cycles(MEM_LAT + 2);
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    logic [31:0] ed;
    for (int k = 0; k < 7; k++) begin
      nxt();
      d_req   = (idx < 2);
      d_we    = 1'b0;
      d_addr  = (idx == 0) ? 32'h200 : 32'h204;
      d_wdata = 32'h0;
      d_size  = 3'b010;
      smp();
      checks++;
      if ({d_gnt, d_rvalid, if_gnt, if_rvalid} !==
          {k == 0 || k == 3, k == 2 || k == 5,
           1'b0, 1'b0}) begin
        errs++;
        $display("FAIL b2b_strobes k=%0d got %b", k,
                 {d_gnt, d_rvalid, if_gnt, if_rvalid});
      end
      ed = (k == 2) ? 32'h11 :
           (k == 5) ? 32'h22 : 32'h0;
      checks++;
      if (d_rdata !== ed) begin
        errs++;
        $display("FAIL b2b_rdata k=%0d got %h want %h",
                 k, d_rdata, ed);
      end
      if (d_gnt) idx++;
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_wait();
    nxt();
    if_req  = 1'b1;
    if_addr = 32'h48;
    smp();
    checks++;
    if (if_gnt !== 1'b1) begin
      errs++;
      $display("FAIL rst_wait_grant got %b want 1", if_gnt);
    end
    nxt();
    if_req = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h600;
    reset  = 1'b0;
    smp();
    checks++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL rst_wait_outputs got %h want 0", outs);
    end
    nxt();
    clr_in();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      checks++;
      if (outs !== '0) begin
        errs++;
        $display("FAIL rst_wait_after k=%0d got %h want 0",
                 k, outs);
      end
      nxt();
    end
    idle_cycles(1);
  endtask

  task automatic test_random();
    bit ip = 0, dp = 0, dwe = 0;
    bit m_out = 0, m_d = 0, m_we = 0;
    bit eig, edg, e_we, e_irv, e_drv;
    logic [31:0] ia = 0, da = 0, dw = 0, m_addr = 0;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [2:0]  dsz = 0, e_sz;
    int m_resp = 0, m_st = 0;
    idle_cycles(3);
    for (int t = 0; t < 600; t++) begin
      nxt();
      if (!ip) begin
        if ($urandom_range(0, 2) == 0) begin
          ip = 1;
          ia = $urandom & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        ip = 0;
      end
      if (!dp) begin
        if ($urandom_range(0, 1) == 0) begin
          dp  = 1;
          dwe = 1'($urandom_range(0, 1));
          da  = $urandom;
          dw  = $urandom;
          dsz = 3'($urandom_range(0, 7));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dp = 0;
      end
      if_req  = ip;
      if_addr = ip ? ia : $urandom;
      d_req   = dp;
      d_we    = dp ? dwe : 1'($urandom_range(0, 1));
      d_addr  = dp ? da : $urandom;
      d_wdata = dp ? dw : $urandom;
      d_size  = dp ? dsz : 3'($urandom_range(0, 7));
      eig = 0; edg = 0; e_we = 0;
      e_irv = 0; e_drv = 0;
      e_addr = 0; e_wd = 0; e_sz = 0;
      e_ird = 0; e_drd = 0;
      if (!m_out) begin
        if (ip && (!dp || m_st == STARVE_MAX)) begin
          eig = 1; e_addr = ia; e_sz = 3'b010;
        end else if (dp) begin
          edg = 1; e_addr = da; e_wd = dw;
          e_sz = dsz; e_we = dwe;
        end
      end else if (cyc == m_resp) begin
        if (m_d) begin
          e_drv = 1;
          e_drd = m_we ? 32'h0 : mem_val(m_addr);
        end else begin
          e_irv = 1;
          e_ird = mem_val(m_addr);
        end
      end
      smp();
      checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we,
           if_rvalid, d_rvalid, busy} !==
          {eig, edg, eig | edg, e_we,
           e_irv, e_drv, m_out}) begin
        errs++;
        $display("FAIL rnd_strobes t=%0d got %b want %b", t,
                 {if_gnt, d_gnt, mem_en, mem_we,
                  if_rvalid, d_rvalid, busy},
                 {eig, edg, eig | edg, e_we,
                  e_irv, e_drv, m_out});
      end
      checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wd
          || mem_size !== e_sz) begin
        errs++;
        $display("FAIL rnd_mem t=%0d got %h %h %b want %h %h %b",
                 t, mem_addr, mem_wdata, mem_size,
                 e_addr, e_wd, e_sz);
      end
      checks++;
      if (if_rdata !== e_ird || d_rdata !== e_drd) begin
        errs++;
        $display("FAIL rnd_rdata t=%0d got %h/%h want %h/%h",
                 t, if_rdata, d_rdata, e_ird, e_drd);
      end
      if (eig || edg) begin
        m_out  = 1;
        m_resp = cyc + MEM_LAT;
        m_d    = edg;
        m_we   = e_we;
        m_addr = e_addr;
      end else if (m_out && cyc == m_resp) begin
        m_out = 0;
      end
      if (eig) begin
        m_st = 0;
        ip   = 0;
      end
      if (edg) begin
        if (ip)
          m_st = (m_st < STARVE_MAX) ? m_st + 1
                                      : STARVE_MAX;
        dp = 0;
      end
    end
    idle_cycles(MEM_LAT + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port. Arbitrates, issues one access at a time, times the memory latency and routes the read data back to the owning requester. Stall decisions stay with the pipeline; this block provides the grant/valid handshake that drives them. Data accesses have priority, and a starvation guard keeps fetch from being locked out.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1)
STARVE_MAX, 4, consecutive IF losses before IF is forced to win (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse; fetch request accepted
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held with fields stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_size  in  3  transfer-size code, passed through unmodified
d_gnt  out  1  one-cycle pulse; data request accepted
d_rvalid  out  1  one-cycle pulse; load data valid or store complete
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe (one cycle)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_size  out  3  memory size code
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  access outstanding

Behaviour:
- States: IDLE, WAIT. The owner register (NONE/IF/D) and the latency counter are held alongside the state.
- Reset (reset=0, async): state IDLE, owner NONE, counter 0, starvation count 0. All outputs are 0, including the rdata buses. A response in flight is dropped; the memory result arriving after reset is ignored.
- IDLE, no request: all strobes 0 and mem_* = 0.
- IDLE with a request (arbitration is combinational in the same cycle):
  - Only one requester active: that requester wins.
  - Both active: D wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - The winner gets gnt=1 in this cycle. mem_en=1, and mem_we/addr/wdata/size are driven from the winner. For IF, mem_we=0, mem_wdata=0 and mem_size=3'b010.
  - Owner is latched, counter is loaded with MEM_LAT, and the state moves to WAIT.
- Starvation count:
  - Increments (saturating at STARVE_MAX) on each grant to D while if_req=1.
  - Clears to 0 on any grant to IF.
  - Holds otherwise.
- WAIT: counter decrements each cycle. The cycle it reaches 1 is the response cycle:
  - <owner>_rvalid=1 and <owner>_rdata=mem_rdata.
  - For a store, d_rdata=0 and d_rvalid still pulses.
  - Next state IDLE, owner NONE.
- Timing: grant at cycle N gives rvalid at cycle N+MEM_LAT. The next grant is possible at N+MEM_LAT+1. Throughput is one access per MEM_LAT+1 cycles.
- busy=1 from the cycle after the grant through the response cycle inclusive.
- A request arriving during WAIT is not granted until IDLE. The non-owner port never sees gnt or rvalid.
- Requester dropping req before gnt: no effect, nothing issued. Changing fields while req=1 before gnt is illegal; the bench checks for it with an assertion.
- rdata outputs are 0 in every cycle their rvalid is 0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, WAIT}
  - typedef arb_owner_t {OWN_NONE, OWN_IF, OWN_D}
  - constant SIZE_WORD = 3'b010
- Sub-module starve_counter (params MAX). Inputs: clk, reset, clr, inc. Output: at_max. It isolates the saturating starvation logic.
- The FSM, latency counter and output muxing stay in unified_mem_arbiter.

Test Plan:
1. Reset mid-WAIT: IF granted at cycle 10, reset=0 at cycle 11, released at 12 -> no if_rvalid ever; busy=0 and all outputs 0 from cycle 11.
2. Lone fetch: if_req=1, if_addr=0x40 at cycle 5, memory returns 0x00500093 -> if_gnt and mem_en at 5 with mem_addr=0x40 and mem_we=0; if_rvalid at 7 with if_rdata=0x00500093; busy=1 at cycles 6-7.
3. Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xAB, d_size=0 -> mem_we=1, mem_wdata=0xAB, mem_size=0 at the grant; d_rvalid two cycles later with d_rdata=0.
4. Simultaneous requests: if_req and d_req both 1 at cycle 3 -> d_gnt at 3 and if_gnt at 6 (next IDLE); d_rvalid at 5 and if_rvalid at 8.
5. Starvation: if_req held, d_req re-asserted continuously -> exactly 4 consecutive d_gnt, then if_gnt on the 5th grant, then starve count back to 0.
6. Back-to-back loads from D at 0x200 and 0x204 with data 0x11 and 0x22 -> grants 3 cycles apart; d_rdata 0x11 then 0x22; if_gnt and if_rvalid never pulse.
